reg_writeback_unit: RTL and testbench
=====================================

// Module: reg_writeback_unit
// PURPOSE
//   Write side of the register file: collects write-back requests from the ALU path,
//   the load/SRAM path and clear requests, then buffers them in an in-order FIFO.
//   Retires exactly one request per cycle onto the register file's write port.
//   Publishes a pending-destination mask so the hazard unit can stall readers of
//   registers that still have a queued write.
// PARAMETERS
//   WORD_LEN    32  data width of a register
//   REG_COUNT   15  number of architectural registers; REG_IDX_W = $clog2(REG_COUNT)
//   FIFO_DEPTH  4   queued requests, power of two, >= 2
// PORTS
//   clk           in   1          system clock; all state updates on posedge
//   rst           in   1          reset, asynchronous, active-high
//   clr_valid     in   1          clear request
//   clr_ready     out  1          clear request accepted this cycle
//   clr_dest      in   REG_IDX_W  register to zero
//   ld_valid      in   1          load-data write request
//   ld_ready      out  1          load request accepted
//   ld_dest       in   REG_IDX_W  load destination
//   ld_data       in   WORD_LEN   load data
//   alu_valid     in   1          ALU-result write request
//   alu_ready     out  1          ALU request accepted
//   alu_dest      in   REG_IDX_W  ALU destination
//   alu_result    in   WORD_LEN   ALU result
//   wb_dest       out  REG_IDX_W  to register file destination index
//   wb_result     out  WORD_LEN   to register file write data
//   wb_en         out  1          to register file write enable
//   wb_sclr       out  1          to register file synchronous clear
//   pending_mask  out  REG_COUNT  bit r = 1 iff a queued entry targets r
//   full          out  1          FIFO holds FIFO_DEPTH entries
//   empty         out  1          FIFO holds no entries
//   bad_dest      out  1          sticky: a request with dest >= REG_COUNT was seen
// BEHAVIOUR
//   Reset (async, rst=1): pointers=0, count=0, bad_dest=0. Outputs are then
//     empty=1, full=0, wb_en=0, wb_sclr=0, wb_dest=0, wb_result=0, pending_mask=0.
//     All *_ready=0 while rst is high. FIFO contents are don't-care.
//     Reset mid-operation discards every queued entry; nothing is retired.
//   Handshake: a transfer occurs on a posedge where valid && ready. At most one enqueue per cycle.
//     Fixed priority: clr > ld > alu. ready = !rst && !full && no higher-priority valid.
//     When full, every ready is 0, even if a pop happens in the same cycle.
//     A requester holds valid and payload stable until it sees ready.
//   Entry = {is_clr, dest, data}. A clear enqueues with data = 0.
//   Bad dest (>= REG_COUNT): the request is handshaken, not enqueued, and sets bad_dest.
//   Retire: while !empty, the head drives wb_* combinationally.
//     wb_en = !head.is_clr, wb_sclr = head.is_clr (mutually exclusive).
//     The register file writes on negedge. The head pops on the following posedge.
//     Exactly one retire per cycle; there is no backpressure from the register file.
//   When empty: wb_en=0, wb_sclr=0, wb_dest=0, wb_result=0.
//   Latency: enqueue at posedge N -> wb_* valid during cycle N+1 -> regfile written
//     at the negedge of cycle N+1 -> popped at posedge N+2. No bypass from input to wb_*.
//   Simultaneous push and pop with count not full: count unchanged, pointers both advance.
//   Pointers wrap modulo FIFO_DEPTH. count is $clog2(FIFO_DEPTH)+1 bits.
//   pending_mask = OR over valid entries of onehot(dest). It is combinational from FIFO state.
//     It includes the head until the head pops. Duplicate destinations are allowed; order is preserved.
// STRUCTURE
//   Shared package wb_pkg: REG_IDX_W, typedef wb_entry_t {is_clr, dest, data},
//     localparams SRC_CLR=0, SRC_LD=1, SRC_ALU=2 for the priority encoder.
//   Sub-module wb_fifo: synchronous FIFO of wb_entry_t, async reset, push/pop/full/empty/count,
//     exposes per-entry valid+dest for the mask.
//   Top level holds the priority arbiter, dest check, output muxing and mask.
// TESTING
//   1 Reset, then alu_valid dest=3 result=0xDEAD -> cycle N+1: wb_en=1 wb_dest=3 wb_result=0xDEAD; empty at N+2.
//   2 clr, ld, alu valid together (dests 1,2,4) -> accepted one per cycle in order clr, ld, alu;
//     retired as sclr@1, then en@2, then en@4.
//   3 Hold alu_valid for 6 cycles with retire running -> no entry lost, wb sequence matches input order,
//     full never asserts.
//   4 Push 4 entries with zero pops first (a bench-only pop-inhibit force) -> full=1, all readies 0;
//     after one pop, ready returns the next cycle.
//   5 Queue dest 5 twice -> pending_mask[5]=1 until the second pop, then 0.
//     Dest 15 -> bad_dest=1 and nothing is retired.
//   6 Assert rst with 3 entries queued -> immediately wb_en=0, empty=1, pending_mask=0; no retire after release.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and sizing for the register write-back path.
// Entries carry a clear flag, destination index and write data.
package wb_pkg;
  localparam int WORD_LEN   = 32;
  localparam int REG_COUNT  = 15;
  localparam int FIFO_DEPTH = 4;
  localparam int REG_IDX_W  = $clog2(REG_COUNT);
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = PTR_W + 1;

  localparam logic [1:0] SRC_CLR  = 2'd0;
  localparam logic [1:0] SRC_LD   = 2'd1;
  localparam logic [1:0] SRC_ALU  = 2'd2;
  localparam logic [1:0] SRC_NONE = 2'd3;

  typedef struct packed {
    logic                 is_clr;
    logic [REG_IDX_W-1:0] dest;
    logic [WORD_LEN-1:0]  data;
  } wb_entry_t;
endpackage

// File: rtl/wb_if.sv
// Request handshakes, register-file write port and status of the
// write-back unit.
interface wb_if;
  import wb_pkg::*;

  logic                 clr_valid;
  logic                 clr_ready;
  logic [REG_IDX_W-1:0] clr_dest;
  logic                 ld_valid;
  logic                 ld_ready;
  logic [REG_IDX_W-1:0] ld_dest;
  logic [WORD_LEN-1:0]  ld_data;
  logic                 alu_valid;
  logic                 alu_ready;
  logic [REG_IDX_W-1:0] alu_dest;
  logic [WORD_LEN-1:0]  alu_result;
  logic [REG_IDX_W-1:0] wb_dest;
  logic [WORD_LEN-1:0]  wb_result;
  logic                 wb_en;
  logic                 wb_sclr;
  logic [REG_COUNT-1:0] pending_mask;
  logic                 full;
  logic                 empty;
  logic                 bad_dest;

  modport master (
    output clr_valid, clr_dest,
    output ld_valid, ld_dest, ld_data,
    output alu_valid, alu_dest, alu_result,
    input  clr_ready, ld_ready, alu_ready,
    input  wb_dest, wb_result, wb_en, wb_sclr,
    input  pending_mask, full, empty, bad_dest
  );

  modport slave (
    input  clr_valid, clr_dest,
    input  ld_valid, ld_dest, ld_data,
    input  alu_valid, alu_dest, alu_result,
    output clr_ready, ld_ready, alu_ready,
    output wb_dest, wb_result, wb_en, wb_sclr,
    output pending_mask, full, empty, bad_dest
  );
endinterface

// File: rtl/wb_fifo.sv
// In-order FIFO of write-back entries; exposes per-slot valid and
// destination so the top can build the pending mask.
module wb_fifo
  import wb_pkg::*;
(
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 push_i,
  input  wb_entry_t                            din_i,
  input  logic                                 pop_i,
  output wb_entry_t                            head_o,
  output logic                                 full_o,
  output logic                                 empty_o,
  output logic [FIFO_DEPTH-1:0]                ent_vld_o,
  output logic [FIFO_DEPTH-1:0][REG_IDX_W-1:0] ent_dest_o
);
  wb_entry_t        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;
  logic [PTR_W-1:0] off;

  assign full_o  = cnt_q == CNT_W'(FIFO_DEPTH);
  assign empty_o = cnt_q == '0;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_q];

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: ;
    endcase
  end

  // A slot is live when its distance from the head is below the count.
  always_comb begin
    off        = '0;
    ent_vld_o  = '0;
    ent_dest_o = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      off           = PTR_W'(i) - rd_q;
      ent_vld_o[i]  = {1'b0, off} < cnt_q;
      ent_dest_o[i] = mem_q[i].dest;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end
endmodule

// File: rtl/reg_writeback_unit.sv
// Register-file write side: arbitrates clr/ld/alu requests into an
// in-order queue and retires one entry per cycle.
module reg_writeback_unit
  import wb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  wb_if.slave  io
);
  wb_entry_t                            din;
  wb_entry_t                            head;
  logic [1:0]                           src;
  logic                                 acc;
  logic                                 fire;
  logic                                 bad;
  logic                                 push;
  logic                                 pop;
  logic                                 full;
  logic                                 empty;
  logic                                 bad_dest_q, bad_dest_d;
  logic [FIFO_DEPTH-1:0]                ent_vld;
  logic [FIFO_DEPTH-1:0][REG_IDX_W-1:0] ent_dest;
  logic [REG_COUNT-1:0]                 mask;

  assign acc          = !rst && !full;
  assign io.clr_ready = acc;
  assign io.ld_ready  = acc && !io.clr_valid;
  assign io.alu_ready = acc && !io.clr_valid && !io.ld_valid;

  always_comb begin
    src = SRC_NONE;
    din = '0;
    priority case (1'b1)
      io.clr_valid: begin
        src        = SRC_CLR;
        din.is_clr = 1'b1;
        din.dest   = io.clr_dest;
      end
      io.ld_valid: begin
        src      = SRC_LD;
        din.dest = io.ld_dest;
        din.data = io.ld_data;
      end
      io.alu_valid: begin
        src      = SRC_ALU;
        din.dest = io.alu_dest;
        din.data = io.alu_result;
      end
      default: ;
    endcase
  end

  // Out-of-range requests complete the handshake but never queue.
  assign fire       = acc && (src != SRC_NONE);
  assign bad        = din.dest >= REG_IDX_W'(REG_COUNT);
  assign push       = fire && !bad;
  assign bad_dest_d = bad_dest_q || (fire && bad);
  assign pop        = !empty;

  wb_fifo u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .din_i      (din),
    .pop_i      (pop),
    .head_o     (head),
    .full_o     (full),
    .empty_o    (empty),
    .ent_vld_o  (ent_vld),
    .ent_dest_o (ent_dest)
  );

  always_comb begin
    mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (ent_vld[i]) mask[ent_dest[i]] = 1'b1;
    end
  end

  assign io.wb_en        = !empty && !head.is_clr;
  assign io.wb_sclr      = !empty && head.is_clr;
  assign io.wb_dest      = empty ? '0 : head.dest;
  assign io.wb_result    = empty ? '0 : head.data;
  assign io.pending_mask = mask;
  assign io.full         = full;
  assign io.empty        = empty;
  assign io.bad_dest     = bad_dest_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bad_dest_q <= 1'b0;
    else     bad_dest_q <= bad_dest_d;
  end
endmodule

// File: tb/tb_reg_writeback_unit.sv
// Randomised and directed bench for reg_writeback_unit against a
// queue-based model of the write-back queue.
module tb_reg_writeback_unit;
  import wb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_if bus ();

  reg_writeback_unit dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  int        n_cmp = 0;
  int        n_bad = 0;
  wb_entry_t mq[$];
  wb_entry_t clr_q[$];
  wb_entry_t ld_q[$];
  wb_entry_t alu_q[$];
  bit        m_bad = 0;
  bit        inhibit = 0;
  int        fire = -1;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    bus.clr_valid  = clr_q.size() > 0;
    bus.clr_dest   = clr_q.size() > 0 ? clr_q[0].dest : '0;
    bus.ld_valid   = ld_q.size() > 0;
    bus.ld_dest    = ld_q.size() > 0 ? ld_q[0].dest : '0;
    bus.ld_data    = ld_q.size() > 0 ? ld_q[0].data : '0;
    bus.alu_valid  = alu_q.size() > 0;
    bus.alu_dest   = alu_q.size() > 0 ? alu_q[0].dest : '0;
    bus.alu_result = alu_q.size() > 0 ? alu_q[0].data : '0;
  endtask

  task automatic add_clr(int d);
    wb_entry_t e;
    e.is_clr = 1'b1;
    e.dest   = REG_IDX_W'(d);
    e.data   = '0;
    clr_q.push_back(e);
  endtask

  task automatic add_ld(int d, logic [WORD_LEN-1:0] v);
    wb_entry_t e;
    e.is_clr = 1'b0;
    e.dest   = REG_IDX_W'(d);
    e.data   = v;
    ld_q.push_back(e);
  endtask

  task automatic add_alu(int d, logic [WORD_LEN-1:0] v);
    wb_entry_t e;
    e.is_clr = 1'b0;
    e.dest   = REG_IDX_W'(d);
    e.data   = v;
    alu_q.push_back(e);
  endtask

  task automatic check_now();
    logic [REG_COUNT-1:0] m;
    logic                 acc;
    bit                   emp;
    m   = '0;
    foreach (mq[i]) m[mq[i].dest] = 1'b1;
    emp = mq.size() == 0;
    acc = !rst && mq.size() < FIFO_DEPTH;
    chk("clr_ready", bus.clr_ready, acc);
    chk("ld_ready", bus.ld_ready, acc && clr_q.size() == 0);
    chk("alu_ready", bus.alu_ready,
        acc && clr_q.size() == 0 && ld_q.size() == 0);
    chk("empty", bus.empty, emp);
    chk("full", bus.full, mq.size() == FIFO_DEPTH);
    chk("mask", bus.pending_mask, m);
    chk("bad_dest", bus.bad_dest, m_bad);
    chk("wb_en", bus.wb_en, !emp && !mq[0].is_clr);
    chk("wb_sclr", bus.wb_sclr, !emp && mq[0].is_clr);
    chk("wb_dest", bus.wb_dest, emp ? 0 : mq[0].dest);
    chk("wb_result", bus.wb_result, emp ? 0 : mq[0].data);
    fire = -1;
    if (acc) begin
      if (clr_q.size() > 0)      fire = 0;
      else if (ld_q.size() > 0)  fire = 1;
      else if (alu_q.size() > 0) fire = 2;
    end
  endtask

  task automatic step();
    wb_entry_t e;
    @(negedge clk);
    check_now();
    @(posedge clk);
    if (!inhibit && mq.size() > 0) void'(mq.pop_front());
    if (fire >= 0) begin
      case (fire)
        0:       e = clr_q.pop_front();
        1:       e = ld_q.pop_front();
        default: e = alu_q.pop_front();
      endcase
      if (e.dest >= REG_COUNT) m_bad = 1;
      else mq.push_back(e);
    end
    #1;
    drive();
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic hold();
    inhibit = 1;
    force dut.pop = 1'b0;
  endtask

  task automatic unhold();
    inhibit = 0;
    release dut.pop;
  endtask

  initial begin
    rst = 1'b1;
    drive();
    run(2);
    rst = 1'b0;

    add_alu(3, 32'hDEAD);
    drive();
    run(4);

    add_clr(1);
    add_ld(2, 32'h1111_2222);
    add_alu(4, 32'h3333_4444);
    drive();
    run(6);

    for (int i = 0; i < 6; i++) add_alu(i + 6, $urandom);
    drive();
    run(10);

    hold();
    for (int i = 0; i < 5; i++) add_alu(i, $urandom);
    drive();
    run(6);
    unhold();
    run(8);

    hold();
    add_alu(5, 32'h55);
    add_ld(5, 32'h66);
    drive();
    run(3);
    unhold();
    run(4);
    add_alu(15, 32'hBAD);
    drive();
    run(4);

    hold();
    for (int i = 0; i < 3; i++) add_alu(i + 7, $urandom);
    drive();
    run(4);
    rst = 1'b1;
    #1;
    chk("rst_wb_en", bus.wb_en, 1'b0);
    chk("rst_empty", bus.empty, 1'b1);
    chk("rst_mask", bus.pending_mask, '0);
    chk("rst_bad", bus.bad_dest, 1'b0);
    chk("rst_alu_rdy", bus.alu_ready, 1'b0);
    mq.delete();
    m_bad = 0;
    unhold();
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive();
    run(4);

    for (int i = 0; i < 400; i++) begin
      if (i % 40 == 10) hold();
      if (i % 40 == 17) unhold();
      if ($urandom_range(0, 5) == 0 && clr_q.size() < 2)
        add_clr($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0 && ld_q.size() < 3)
        add_ld($urandom_range(0, 15), $urandom);
      if ($urandom_range(0, 1) == 0 && alu_q.size() < 3)
        add_alu($urandom_range(0, 15), $urandom);
      drive();
      step();
    end
    unhold();
    run(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
